// File: rtl/kn_stream_recovery_if.sv
// Stream and frame-control bundle for kn_stream_recovery.
// The master drives frame control and samples; the slave returns the Kn stream and status.
interface kn_stream_recovery_if #(
  parameter int unsigned WIDTH = 16
);
  logic                    start;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_data;
  logic                    done;
  logic                    busy;
  logic                    sat_flag;

  modport master (
    output start, in_valid, in_data,
    input  out_valid, out_data, done, busy, sat_flag
  );

  modport slave (
    input  start, in_valid, in_data,
    output out_valid, out_data, done, busy, sat_flag
  );
endinterface

// File: rtl/kn_stream_recovery.sv
// Streaming Kn recovery: quantise residuals to multiples of 2^Q_SHIFT, apply ORDER
// cascaded running sums, and emit a saturated, frame-delimited Kn stream.
module kn_stream_recovery #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned ORDER     = 2,
  parameter int unsigned Q_SHIFT   = 3,
  parameter int unsigned FRAME_LEN = 13
) (
  input logic                clk,
  input logic                reset,
  kn_stream_recovery_if.slave bus
);
  localparam int unsigned CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic signed [ACC_W-1:0] RND =
    (Q_SHIFT > 0) ? (ACC_W'(1) << (Q_SHIFT - 1)) : '0;
  localparam logic [ACC_W-1:0] Q_MASK = ~((ACC_W'(1) << Q_SHIFT) - ACC_W'(1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt;
  logic                    accept_c, last_c;
  logic signed [WIDTH-1:0] x_r;
  logic                    x_v, x_last;
  logic signed [ACC_W-1:0] x_ext_c, q_c;
  logic                    hi_c, lo_c;
  // Stage 0 is the quantised sample; stages 1..ORDER are the integrators.
  logic signed [ACC_W-1:0] s [0:ORDER];
  logic [ORDER:0]          v, lst;

  // A sample is taken while running, or together with the start that opens a frame.
  assign accept_c = bus.in_valid && (bus.start || state == RUN);
  assign last_c   = accept_c && (bus.start ? (FRAME_LEN == 1) : (cnt == LAST_IDX));

  assign x_ext_c = ACC_W'(x_r);
  assign q_c     = (x_ext_c + RND) & Q_MASK;
  assign hi_c    = s[ORDER] > SAT_MAX;
  assign lo_c    = s[ORDER] < SAT_MIN;

  always_comb begin
    state_next = state;
    if (bus.start) begin
      state_next = last_c ? DRAIN : RUN;
    end else begin
      case (state)
        RUN:     if (last_c) state_next = DRAIN;
        DRAIN:   if (bus.done) state_next = IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_next;
      bus.busy <= (state_next != IDLE);
    end
  end

  // Datapath; a start flushes every stage so an aborted frame leaves no trace.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      x_r          <= '0;
      x_v          <= 1'b0;
      x_last       <= 1'b0;
      v            <= '0;
      lst          <= '0;
      for (int k = 0; k <= int'(ORDER); k++) s[k] <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.done      <= 1'b0;
      bus.sat_flag  <= 1'b0;
    end else if (bus.start) begin
      cnt    <= accept_c ? CNT_W'(1) : '0;
      if (accept_c) x_r <= bus.in_data;
      x_v    <= accept_c;
      x_last <= last_c;
      v      <= '0;
      lst    <= '0;
      for (int k = 0; k <= int'(ORDER); k++) s[k] <= '0;
      bus.out_valid <= 1'b0;
      bus.done      <= 1'b0;
      bus.sat_flag  <= 1'b0;
    end else begin
      if (accept_c) begin
        cnt <= cnt + CNT_W'(1);
        x_r <= bus.in_data;
      end
      x_v    <= accept_c;
      x_last <= last_c;
      v[0]   <= x_v;
      lst[0] <= x_last;
      if (x_v) s[0] <= q_c;
      for (int k = 1; k <= int'(ORDER); k++) begin
        v[k]   <= v[k-1];
        lst[k] <= lst[k-1];
        if (v[k-1]) s[k] <= s[k] + s[k-1];
      end
      bus.out_valid <= v[ORDER];
      bus.done      <= v[ORDER] && lst[ORDER];
      if (v[ORDER]) begin
        if (hi_c)      bus.out_data <= SAT_MAX[WIDTH-1:0];
        else if (lo_c) bus.out_data <= SAT_MIN[WIDTH-1:0];
        else           bus.out_data <= s[ORDER][WIDTH-1:0];
        if (hi_c || lo_c) bus.sat_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_kn_stream_recovery.sv
// Bench for kn_stream_recovery: four configurations share one stimulus stream; each
// scenario checks the configuration it targets against constants or a running-sum model.
module tb_kn_stream_recovery;
  localparam int unsigned W = 16;

  typedef struct {
    int data;
    bit valid;
    bit done;
    bit sat;
    bit busy;
    int cyc;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_d = 1'b0;
  logic valid_d = 1'b0;
  logic signed [W-1:0] data_d = '0;
  int cyc = 0;
  int stamp = 0;
  int vectors = 0;
  int miscompares = 0;
  rec_t qa[$], qb[$], qc[$], qd[$];
  int exp_d[$];
  bit exp_s[$];
  int stamps[$];
  int smp[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  kn_stream_recovery_if #(.WIDTH(W)) ia ();
  kn_stream_recovery_if #(.WIDTH(W)) ib ();
  kn_stream_recovery_if #(.WIDTH(W)) ic ();
  kn_stream_recovery_if #(.WIDTH(W)) id ();

  assign ia.start = start_d;  assign ia.in_valid = valid_d;  assign ia.in_data = data_d;
  assign ib.start = start_d;  assign ib.in_valid = valid_d;  assign ib.in_data = data_d;
  assign ic.start = start_d;  assign ic.in_valid = valid_d;  assign ic.in_data = data_d;
  assign id.start = start_d;  assign id.in_valid = valid_d;  assign id.in_data = data_d;

  kn_stream_recovery #(.WIDTH(16), .ACC_W(32), .ORDER(1), .Q_SHIFT(3), .FRAME_LEN(4))
    dut_a (.clk(clk), .reset(reset), .bus(ia));
  kn_stream_recovery #(.WIDTH(16), .ACC_W(32), .ORDER(2), .Q_SHIFT(3), .FRAME_LEN(4))
    dut_b (.clk(clk), .reset(reset), .bus(ib));
  kn_stream_recovery #(.WIDTH(16), .ACC_W(32), .ORDER(1), .Q_SHIFT(3), .FRAME_LEN(3))
    dut_c (.clk(clk), .reset(reset), .bus(ic));
  kn_stream_recovery #(.WIDTH(16), .ACC_W(32), .ORDER(3), .Q_SHIFT(2), .FRAME_LEN(13))
    dut_d (.clk(clk), .reset(reset), .bus(id));

  // Output capture, sampled mid-cycle with the index of the edge that produced it.
  always @(negedge clk) begin
    if (ia.out_valid || ia.done) qa.push_back('{int'(ia.out_data), ia.out_valid, ia.done, ia.sat_flag, ia.busy, cyc});
    if (ib.out_valid || ib.done) qb.push_back('{int'(ib.out_data), ib.out_valid, ib.done, ib.sat_flag, ib.busy, cyc});
    if (ic.out_valid || ic.done) qc.push_back('{int'(ic.out_data), ic.out_valid, ic.done, ic.sat_flag, ic.busy, cyc});
    if (id.out_valid || id.done) qd.push_back('{int'(id.out_data), id.out_valid, id.done, id.sat_flag, id.busy, cyc});
  end

  task automatic drive(input bit st, input bit vl, input int d);
    start_d = st;
    valid_d = vl;
    data_d  = W'(d);
    stamp   = cyc + 1;
    @(posedge clk);
    #1;
    start_d = 1'b0;
    valid_d = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    qa.delete(); qb.delete(); qc.delete(); qd.delete();
    stamps.delete();
  endtask

  // Reference: round half up to a multiple of 2^qs, ORDER running sums in 32-bit, clamp to 16 bits.
  function automatic void model(input int order, input int qs, input int samples[$]);
    int acc[5];
    bit sat;
    sat = 1'b0;
    exp_d.delete();
    exp_s.delete();
    foreach (acc[k]) acc[k] = 0;
    foreach (samples[i]) begin
      acc[0] = ((samples[i] + (1 << (qs - 1))) >>> qs) << qs;
      for (int k = 1; k <= order; k++) acc[k] = acc[k] + acc[k-1];
      if (acc[order] > 32767) begin
        exp_d.push_back(32767); sat = 1'b1;
      end else if (acc[order] < -32768) begin
        exp_d.push_back(-32768); sat = 1'b1;
      end else begin
        exp_d.push_back(acc[order]);
      end
      exp_s.push_back(sat);
    end
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (ia.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", ia.out_valid); end
    vectors++; if (ia.out_data !== 16'sd0) begin miscompares++; $display("FAIL reset_out_data: got %0d want 0", ia.out_data); end
    vectors++; if (ia.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", ia.done); end
    vectors++; if (ia.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", ia.busy); end
    vectors++; if (ia.sat_flag !== 1'b0) begin miscompares++; $display("FAIL reset_sat_flag: got %b want 0", ia.sat_flag); end
    reset = 1'b0;
    qa.delete();
    drive(1'b0, 1'b1, 8);
    idle(6);
    vectors++; if (qa.size() != 0) begin miscompares++; $display("FAIL reset_idle_output: got %0d outputs want 0", qa.size()); end
    vectors++; if (id.busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", id.busy); end
  endtask

  task automatic test_basic();
    int xin[4] = '{0, 8, -16, 8};
    int ea[4]  = '{0, 8, -8, 0};
    int eb[4]  = '{0, 8, 0, 0};
    do_reset();
    drive(1'b1, 1'b0, 0);
    vectors++; if (ia.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_rise: got %b want 1", ia.busy); end
    foreach (xin[i]) begin drive(1'b0, 1'b1, xin[i]); stamps.push_back(stamp); end
    idle(8);
    vectors++; if (qa.size() != 4) begin miscompares++; $display("FAIL basic_o1_count: got %0d want 4", qa.size()); end
    foreach (ea[i]) if (i < qa.size()) begin
      vectors++; if (qa[i].data !== ea[i] || !qa[i].valid) begin miscompares++; $display("FAIL basic_o1_data[%0d]: got %0d want %0d", i, qa[i].data, ea[i]); end
      vectors++; if (qa[i].cyc - stamps[i] != 3) begin miscompares++; $display("FAIL basic_o1_latency[%0d]: got %0d want 3", i, qa[i].cyc - stamps[i]); end
      vectors++; if (qa[i].done !== (i == 3)) begin miscompares++; $display("FAIL basic_o1_done[%0d]: got %b want %b", i, qa[i].done, i == 3); end
    end
    if (qa.size() == 4) begin
      vectors++; if (qa[3].busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_at_done: got %b want 1", qa[3].busy); end
    end
    vectors++; if (ia.busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_fall: got %b want 0", ia.busy); end
    vectors++; if (qb.size() != 4) begin miscompares++; $display("FAIL basic_o2_count: got %0d want 4", qb.size()); end
    foreach (eb[i]) if (i < qb.size()) begin
      vectors++; if (qb[i].data !== eb[i] || !qb[i].valid) begin miscompares++; $display("FAIL basic_o2_data[%0d]: got %0d want %0d", i, qb[i].data, eb[i]); end
      vectors++; if (qb[i].cyc - stamps[i] != 4) begin miscompares++; $display("FAIL basic_o2_latency[%0d]: got %0d want 4", i, qb[i].cyc - stamps[i]); end
    end
  endtask

  task automatic test_gaps();
    int xin[4] = '{0, 8, -16, 8};
    int eb[4]  = '{0, 8, 0, 0};
    do_reset();
    drive(1'b1, 1'b0, 0);
    foreach (xin[i]) begin drive(1'b0, 1'b1, xin[i]); stamps.push_back(stamp); idle(2); end
    idle(8);
    vectors++; if (qb.size() != 4) begin miscompares++; $display("FAIL gaps_count: got %0d want 4", qb.size()); end
    foreach (eb[i]) if (i < qb.size()) begin
      vectors++; if (qb[i].data !== eb[i] || !qb[i].valid) begin miscompares++; $display("FAIL gaps_data[%0d]: got %0d want %0d", i, qb[i].data, eb[i]); end
      vectors++; if (qb[i].cyc - stamps[i] != 4) begin miscompares++; $display("FAIL gaps_latency[%0d]: got %0d want 4", i, qb[i].cyc - stamps[i]); end
      vectors++; if (qb[i].done !== (i == 3)) begin miscompares++; $display("FAIL gaps_done[%0d]: got %b want %b", i, qb[i].done, i == 3); end
    end
  endtask

  task automatic test_rounding();
    int xin[4] = '{3, 1, -5, 4};
    int ea[4]  = '{0, 0, -8, 0};
    do_reset();
    drive(1'b1, 1'b0, 0);
    foreach (xin[i]) drive(1'b0, 1'b1, xin[i]);
    idle(8);
    vectors++; if (qa.size() != 4) begin miscompares++; $display("FAIL round_count: got %0d want 4", qa.size()); end
    foreach (ea[i]) if (i < qa.size()) begin
      vectors++; if (qa[i].data !== ea[i]) begin miscompares++; $display("FAIL round_data[%0d]: got %0d want %0d", i, qa[i].data, ea[i]); end
    end
  endtask

  task automatic test_saturation();
    int ec[3] = '{16384, 32767, 32767};
    bit es[3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    drive(1'b1, 1'b0, 0);
    repeat (3) drive(1'b0, 1'b1, 16384);
    idle(8);
    vectors++; if (qc.size() != 3) begin miscompares++; $display("FAIL sat_count: got %0d want 3", qc.size()); end
    foreach (ec[i]) if (i < qc.size()) begin
      vectors++; if (qc[i].data !== ec[i]) begin miscompares++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, qc[i].data, ec[i]); end
      vectors++; if (qc[i].sat !== es[i]) begin miscompares++; $display("FAIL sat_flag[%0d]: got %b want %b", i, qc[i].sat, es[i]); end
    end
    vectors++; if (ic.sat_flag !== 1'b1) begin miscompares++; $display("FAIL sat_sticky: got %b want 1", ic.sat_flag); end
    drive(1'b1, 1'b0, 0);
    vectors++; if (ic.sat_flag !== 1'b0) begin miscompares++; $display("FAIL sat_clear_on_start: got %b want 0", ic.sat_flag); end
  endtask

  task automatic test_frame_control();
    do_reset();
    drive(1'b1, 1'b0, 0);
    repeat (5) drive(1'b0, 1'b1, 8);
    idle(8);
    vectors++; if (qa.size() != 4) begin miscompares++; $display("FAIL frame_extra_count: got %0d want 4", qa.size()); end
    if (qa.size() == 4) begin
      vectors++; if (qa[3].data !== 32 || qa[3].done !== 1'b1) begin miscompares++; $display("FAIL frame_extra_last: got %0d/%b want 32/1", qa[3].data, qa[3].done); end
    end
    qa.delete();
    repeat (3) drive(1'b0, 1'b1, 8);
    idle(8);
    vectors++; if (qa.size() != 0) begin miscompares++; $display("FAIL frame_idle_valid: got %0d outputs want 0", qa.size()); end
    // Abort after two samples; the restart also carries sample 0 of the new frame.
    qa.delete();
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 800);
    drive(1'b0, 1'b1, 800);
    smp = '{24, -8, 16, 0};
    drive(1'b1, 1'b1, smp[0]); stamps.push_back(stamp);
    for (int i = 1; i < 4; i++) drive(1'b0, 1'b1, smp[i]);
    idle(8);
    model(1, 3, smp);
    vectors++; if (qa.size() != 4) begin miscompares++; $display("FAIL abort_count: got %0d want 4", qa.size()); end
    foreach (exp_d[i]) if (i < qa.size()) begin
      vectors++; if (qa[i].data !== exp_d[i] || !qa[i].valid) begin miscompares++; $display("FAIL abort_data[%0d]: got %0d want %0d", i, qa[i].data, exp_d[i]); end
      vectors++; if (qa[i].done !== (i == 3)) begin miscompares++; $display("FAIL abort_done[%0d]: got %b want %b", i, qa[i].done, i == 3); end
    end
    if (qa.size() > 0) begin
      vectors++; if (qa[0].cyc - stamps[0] != 3) begin miscompares++; $display("FAIL abort_latency: got %0d want 3", qa[0].cyc - stamps[0]); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 0);
    drive(1'b0, 1'b1, 8);
    drive(1'b0, 1'b1, 8);
    idle(1);
    vectors++; if (ia.busy !== 1'b1) begin miscompares++; $display("FAIL areset_busy_before: got %b want 1", ia.busy); end
    #4 reset = 1'b1;
    #1;
    vectors++; if (ia.busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy: got %b want 0", ia.busy); end
    vectors++; if (ia.out_valid !== 1'b0) begin miscompares++; $display("FAIL areset_out_valid: got %b want 0", ia.out_valid); end
    vectors++; if (ia.done !== 1'b0) begin miscompares++; $display("FAIL areset_done: got %b want 0", ia.done); end
    vectors++; if (ib.busy !== 1'b0) begin miscompares++; $display("FAIL areset_busy_o2: got %b want 0", ib.busy); end
    qa.delete(); qb.delete();
    @(posedge clk);
    #5 reset = 1'b0;
    @(posedge clk);
    #1;
    repeat (4) drive(1'b0, 1'b1, 8);
    idle(8);
    vectors++; if (qa.size() != 0) begin miscompares++; $display("FAIL areset_no_output: got %0d outputs want 0", qa.size()); end
    vectors++; if (qb.size() != 0) begin miscompares++; $display("FAIL areset_no_output_o2: got %0d outputs want 0", qb.size()); end
  endtask

  task automatic test_random();
    int x;
    do_reset();
    for (int f = 0; f < 12; f++) begin
      smp.delete(); stamps.delete(); qd.delete();
      if ($urandom_range(0, 1) == 1) begin
        x = int'($urandom_range(0, 400)) - 200;
        drive(1'b1, 1'b1, x); smp.push_back(x); stamps.push_back(stamp);
      end else begin
        drive(1'b1, 1'b0, 0);
      end
      while (smp.size() < 13) begin
        repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 0);
        if (f % 2 == 0) x = int'($urandom_range(0, 400)) - 200;
        else x = int'($urandom_range(0, 65535)) - 32768;
        drive(1'b0, 1'b1, x); smp.push_back(x); stamps.push_back(stamp);
      end
      repeat ($urandom_range(0, 3)) drive(1'b0, 1'b1, int'($urandom_range(0, 100)));
      idle(8);
      model(3, 2, smp);
      vectors++; if (qd.size() != 13) begin miscompares++; $display("FAIL rand_count f%0d: got %0d want 13", f, qd.size()); end
      foreach (exp_d[i]) if (i < qd.size()) begin
        vectors++;
        if (qd[i].data !== exp_d[i] || qd[i].sat !== exp_s[i] || qd[i].done !== (i == 12) ||
            !qd[i].valid || qd[i].cyc - stamps[i] != 5) begin
          miscompares++;
          $display("FAIL rand f%0d[%0d]: got %0d sat %b done %b lat %0d want %0d sat %b done %b lat 5",
                   f, i, qd[i].data, qd[i].sat, qd[i].done, qd[i].cyc - stamps[i], exp_d[i], exp_s[i], i == 12);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_rounding();
    test_saturation();
    test_frame_control();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/kn_stream_recovery.md
# kn_stream_recovery

Streaming, parametrised successor to the fixed 13-entry Kn computation in the modulo-recovery chain. It accepts residual difference samples one per cycle and quantises each one to the nearest multiple of 2^Q_SHIFT (2λ). It then applies ORDER cascaded anti-difference (running-sum) stages and emits the saturated Kn sequence for a frame of FRAME_LEN samples. It sits between the difference/residual stage and the unfolding adder, and replaces array-in/array-out operation with a valid-qualified stream plus frame control.

## Interface
- WIDTH, 16: signed sample width, input and output.
- ACC_W, 32: internal accumulator width; must be at least WIDTH.
- ORDER, 2: number of anti-difference stages, 1..4.
- Q_SHIFT, 3: log2 of the quantisation step (2λ = 8).
- FRAME_LEN, 13: samples per frame, at least 1.
- clk  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that opens a new frame.
- in_valid  in  1  qualifies in_data.
- in_data  in  WIDTH  signed residual sample.
- out_valid  out  1  qualifies out_data.
- out_data  out  WIDTH  signed Kn sample, saturated.
- done  out  1  one-cycle pulse, coincident with the last out_valid of a frame.
- busy  out  1  high whenever state ≠ IDLE.
- sat_flag  out  1  sticky; set when any output of the current frame saturated.

## Operation
- States:
  - IDLE: in_valid is ignored.
  - RUN: in_valid samples are accepted and counted, 0..FRAME_LEN-1.
  - DRAIN: waits for the pipeline to empty.
  - Back to IDLE after done.
- Transitions:
  - start moves any state to RUN.
  - In RUN, acceptance of sample FRAME_LEN-1 moves to DRAIN.
  - In DRAIN, the cycle done is asserted moves to IDLE.
- start from RUN or DRAIN aborts the frame:
  - All stage valids and accumulators are cleared, the sample counter is cleared and sat_flag is cleared.
  - No done is produced for the aborted frame.
- in_valid together with start in the same cycle: the sample is accepted as sample 0 of the new frame.
- in_valid in DRAIN or IDLE: ignored. It produces no output and does not advance the count.
- Quantise stage:
  - q = ((x + 2^(Q_SHIFT-1)) >>> Q_SHIFT) << Q_SHIFT.
  - x is sign-extended to ACC_W before rounding; rounding is half toward +∞.
- Stage k, for k = 1..ORDER: s_k ← s_k + s_(k-1) on a valid beat, with s_0 = q. The arithmetic is ACC_W two's complement and wraps.
- Output stage: s_ORDER is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. A clamp event sets sat_flag.
- Accumulators are cleared at start. They hold their value on non-valid beats, so gaps in in_valid are allowed.
- No backpressure: the consumer must accept every out_valid beat.

## Timing
- Reset values: out_valid=0, out_data=0, done=0, busy=0, sat_flag=0, state=IDLE, all accumulators and stage valids 0.
- Latency: sample accepted at edge t appears at edge t+ORDER+2 (quantise register, ORDER integrators, output register).
- Throughput: one sample per clock.
- done is asserted on the same edge as out_valid for the output of sample FRAME_LEN-1.
- busy rises on the edge after start and falls on the edge after done.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously). No further out_valid appears until a new start.
- start with no in_valid: busy rises, and outputs appear only for subsequently accepted samples.

## Test plan
- Basic, ORDER=1, Q_SHIFT=3, FRAME_LEN=4: start, then inputs 0, 8, -16, 8 on consecutive cycles -> out_data 0, 8, -8, 0. The first output arrives 3 cycles after the first input, and done arrives with the value 0.
- ORDER=2, same inputs -> 0, 8, 0, 0, latency 4. Check with in_valid gaps of 2 cycles between samples -> same values, done on the 4th output.
- Rounding, ORDER=1, FRAME_LEN=4: inputs 3, 1, -5, 4 -> quantised 0, 0, -8, 8 -> outputs 0, 0, -8, 0.
- Saturation, WIDTH=16, ORDER=1, FRAME_LEN=3: inputs 16384, 16384, 16384 -> 16384, 32767, 32767. sat_flag goes high on the second output and stays high until the next start.
- Frame control:
  - 5 valid inputs with FRAME_LEN=4 -> only 4 outputs; the 5th input is ignored.
  - in_valid while IDLE -> no output.
  - start after 2 samples of a frame -> no done for that frame, and the new frame restarts from cleared accumulators.
- Async reset 1 cycle after the 2nd sample of a frame -> out_valid, busy and done drop at once, and no output appears until the next start.
